rat_flag_intr_unit: RTL

Flag and interrupt-status stage directly downstream of the RAT control unit. It executes the control unit's flag and interrupt strobes and returns C_FLAG, Z_FLAG and INTV to it. It holds the C/Z flags, the shadow flags used on interrupt entry and exit, and the interrupt-enable bit. It edge-detects and latches the external interrupt request and counts requests lost while one is already pending.

---
 rtl/rat_pkg.sv | 15 +
 rtl/rat_flag_intr_unit_if.sv | 38 +++
 rtl/rat_intr_detect.sv | 59 +++++
 rtl/rat_flag_intr_unit.sv | 75 +++++++
 4 files changed

// File: rtl/rat_pkg.sv
// Shared types and constants for the RAT flag/interrupt stage.
package rat_pkg;

  localparam int unsigned LOST_CNT_W = 8;

  // FLG_LD_SEL encodings
  localparam logic FLG_SRC_ALU  = 1'b0;
  localparam logic FLG_SRC_SHAD = 1'b1;

  typedef struct packed {
    logic c;
    logic z;
  } flags_t;

endpackage : rat_pkg

// File: rtl/rat_flag_intr_unit_if.sv
// Control-unit <-> flag/interrupt stage bus; master is the control unit side.
interface rat_flag_intr_unit_if
  import rat_pkg::*;
#(
  parameter int unsigned CNT_W = LOST_CNT_W
);

  logic             C_IN;
  logic             Z_IN;
  logic             C_LD;
  logic             Z_LD;
  logic             C_SET;
  logic             C_CLEAR;
  logic             FLG_LD_SEL;
  logic             FLG_SHAD_LD;
  logic             I_SET;
  logic             I_CLR;
  logic             INTR;
  logic             INT_ACK;
  logic             C_FLAG;
  logic             Z_FLAG;
  logic             I_FLAG;
  logic             INTV;
  logic [CNT_W-1:0] LOST_CNT;

  modport master (
    output C_IN, Z_IN, C_LD, Z_LD, C_SET, C_CLEAR, FLG_LD_SEL, FLG_SHAD_LD,
           I_SET, I_CLR, INTR, INT_ACK,
    input  C_FLAG, Z_FLAG, I_FLAG, INTV, LOST_CNT
  );

  modport slave (
    input  C_IN, Z_IN, C_LD, Z_LD, C_SET, C_CLEAR, FLG_LD_SEL, FLG_SHAD_LD,
           I_SET, I_CLR, INTR, INT_ACK,
    output C_FLAG, Z_FLAG, I_FLAG, INTV, LOST_CNT
  );

endinterface : rat_flag_intr_unit_if

// File: rtl/rat_intr_detect.sv
// Interrupt request edge detect, pending latch and saturating lost counter.
// Optional macro RAT_INTR_SYNC_EN adds a two-flop input synchronizer.
module rat_intr_detect
  import rat_pkg::*;
#(
  parameter int unsigned CNT_W = LOST_CNT_W
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             intr,
  input  logic             int_ack,
  output logic             pending,
  output logic [CNT_W-1:0] lost_cnt
);

  logic intr_s;
  logic hist;
  logic rise;

`ifdef RAT_INTR_SYNC_EN
  logic sync_a;
  logic sync_b;

  // Two-flop synchronizer; resets high so a held request is not seen as an edge
  always_ff @(posedge clk) begin
    if (RESET) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
    end else begin
      sync_a <= intr;
      sync_b <= sync_a;
    end
  end

  assign intr_s = sync_b;
`else
  assign intr_s = intr;
`endif

  assign rise = intr_s & ~hist;

  // Edge history, pending request and dropped-request counter
  always_ff @(posedge clk) begin
    if (RESET) begin
      hist     <= 1'b1;
      pending  <= 1'b0;
      lost_cnt <= '0;
    end else begin
      hist <= intr_s;
      if (rise)
        pending <= 1'b1;
      else if (int_ack)
        pending <= 1'b0;
      if (rise && pending && !int_ack && (lost_cnt != {CNT_W{1'b1}}))
        lost_cnt <= lost_cnt + CNT_W'(1);
    end
  end

endmodule : rat_intr_detect

// File: rtl/rat_flag_intr_unit.sv
// RAT flag and interrupt-status stage: C/Z flags, shadow flags, interrupt
// enable, and request tracking. Optional macro: RAT_INTR_SYNC_EN.
module rat_flag_intr_unit
  import rat_pkg::*;
#(
  parameter int unsigned CNT_W = LOST_CNT_W
) (
  input  logic                 clk,
  input  logic                 RESET,
  rat_flag_intr_unit_if.slave  bus
);

  flags_t flags_q, flags_d;
  flags_t shad_q, shad_d;
  flags_t src;
  logic   i_q, i_d;
  logic   pending;

  // Flag/shadow/enable next-state; shadow capture uses pre-update flags
  always_comb begin
    flags_d = flags_q;
    shad_d  = shad_q;
    i_d     = i_q;
    src     = (bus.FLG_LD_SEL == FLG_SRC_SHAD) ? shad_q
                                                : flags_t'{c: bus.C_IN, z: bus.Z_IN};

    if (bus.C_CLEAR)
      flags_d.c = 1'b0;
    else if (bus.C_SET)
      flags_d.c = 1'b1;
    else if (bus.C_LD)
      flags_d.c = src.c;

    if (bus.Z_LD)
      flags_d.z = src.z;

    if (bus.FLG_SHAD_LD)
      shad_d = flags_q;

    if (bus.I_CLR)
      i_d = 1'b0;
    else if (bus.I_SET)
      i_d = 1'b1;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (RESET) begin
      flags_q <= '0;
      shad_q  <= '0;
      i_q     <= 1'b0;
    end else begin
      flags_q <= flags_d;
      shad_q  <= shad_d;
      i_q     <= i_d;
    end
  end

  rat_intr_detect #(
    .CNT_W (CNT_W)
  ) u_intr_detect (
    .clk      (clk),
    .RESET    (RESET),
    .intr     (bus.INTR),
    .int_ack  (bus.INT_ACK),
    .pending  (pending),
    .lost_cnt (bus.LOST_CNT)
  );

  assign bus.C_FLAG = flags_q.c;
  assign bus.Z_FLAG = flags_q.z;
  assign bus.I_FLAG = i_q;
  assign bus.INTV   = i_q & pending;

endmodule : rat_flag_intr_unit
